// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin register file write arbiter with pending-write scoreboard
// Optional: REGWR_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead of round-robin.
module regfile_wr_arbiter #(
   parameter int TAM  = 16,
   parameter int NREQ = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [4*NREQ-1:0]     req_sel,
   input  logic [TAM*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  wr_en,
   output logic [3:0]            wr_sel,
   output logic [TAM-1:0]        wr_data,
   input  logic                  rsv_valid,
   input  logic [3:0]            rsv_sel,
   output logic                  rsv_ready,
   input  logic [3:0]            rd_sel_a,
   input  logic [3:0]            rd_sel_b,
   output logic                  hazard_a,
   output logic                  hazard_b,
   output logic [15:0]           busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] grant;
   logic [PW-1:0]   gidx;
   logic            gfound;
   logic            transfer;
   logic [3:0]      gsel;
   logic [TAM-1:0]  gdata;
   logic [15:0]     busy_next;

`ifndef REGWR_FIXED_PRIO_EN
   logic [PW-1:0]   ptr;
`endif

   // First valid requester at or after the search start wins.
   always_comb begin
      int idx;
      grant  = '0;
      gidx   = '0;
      gfound = 1'b0;
      idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
`ifdef REGWR_FIXED_PRIO_EN
         idx = k;
`else
         idx = (int'(ptr) + k) % NREQ;
`endif
         if (!gfound && req_valid[idx]) begin
            gfound     = 1'b1;
            grant[idx] = 1'b1;
            gidx       = PW'(idx);
         end
      end
   end

   assign req_ready = rst ? '0 : grant;
   assign transfer  = gfound & ~rst;
   assign gsel      = req_sel[4*int'(gidx) +: 4];
   assign gdata     = req_data[TAM*int'(gidx) +: TAM];

   assign rsv_ready = ~rst & ~busy[rsv_sel];
   assign hazard_a  = busy[rd_sel_a];
   assign hazard_b  = busy[rd_sel_b];

   // Clear on the strobe edge, then set; a same-edge reservation keeps the bit.
   always_comb begin
      busy_next = busy;
      if (wr_en)
         busy_next[wr_sel] = 1'b0;
      if (rsv_valid && rsv_ready)
         busy_next[rsv_sel] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en   <= 1'b0;
         wr_sel  <= 4'd0;
         wr_data <= '0;
         busy    <= 16'h0000;
`ifndef REGWR_FIXED_PRIO_EN
         ptr     <= '0;
`endif
      end else begin
         wr_en <= transfer;
         busy  <= busy_next;
         if (transfer) begin
            wr_sel  <= gsel;
            wr_data <= gdata;
`ifndef REGWR_FIXED_PRIO_EN
            ptr     <= PW'((int'(gidx) + 1) % NREQ);
`endif
         end
      end
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed and randomized self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

   localparam int TAM  = 16;
   localparam int NREQ = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [4*NREQ-1:0]   req_sel;
   logic [TAM*NREQ-1:0] req_data;
   logic [NREQ-1:0]     req_ready;
   logic                wr_en;
   logic [3:0]          wr_sel;
   logic [TAM-1:0]      wr_data;
   logic                rsv_valid;
   logic [3:0]          rsv_sel;
   logic                rsv_ready;
   logic [3:0]          rd_sel_a;
   logic [3:0]          rd_sel_b;
   logic                hazard_a;
   logic                hazard_b;
   logic [15:0]         busy;

   always #5 clk = ~clk;

   regfile_wr_arbiter #(.TAM(TAM), .NREQ(NREQ)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_sel(req_sel), .req_data(req_data), .req_ready(req_ready),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .rsv_valid(rsv_valid), .rsv_sel(rsv_sel), .rsv_ready(rsv_ready),
      .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
      .hazard_a(hazard_a), .hazard_b(hazard_b), .busy(busy)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: pointer as an integer, scoreboard as a bit array.
   int             m_ptr;
   bit             m_busy [16];
   logic           m_wr_en;
   logic [3:0]     m_wr_sel;
   logic [TAM-1:0] m_wr_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0;
      foreach (m_busy[r]) m_busy[r] = 1'b0;
      m_wr_en   = 1'b0;
      m_wr_sel  = 4'd0;
      m_wr_data = '0;
   endtask

   function automatic int model_grant();
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (m_ptr + k) % NREQ;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [15:0] model_busy();
      logic [15:0] v;
      for (int r = 0; r < 16; r++) v[r] = m_busy[r];
      return v;
   endfunction

   // Called at posedge+1 with inputs set; checks mid-cycle, advances model, returns at next posedge+1.
   task automatic cycle(output logic [NREQ-1:0] rr, output logic rs, output logic ha, output logic hb);
      int              g;
      logic [NREQ-1:0] exp_rr;
      bit              nb [16];
      #3;
      g = model_grant();
      exp_rr = '0;
      if (g >= 0) exp_rr[g] = 1'b1;
      rr = req_ready; rs = rsv_ready; ha = hazard_a; hb = hazard_b;
      check("req_ready", req_ready, exp_rr);
      check("rsv_ready", rsv_ready, !m_busy[rsv_sel]);
      check("hazard_a", hazard_a, m_busy[rd_sel_a]);
      check("hazard_b", hazard_b, m_busy[rd_sel_b]);
      check("busy", busy, model_busy());
      check("wr_en", wr_en, m_wr_en);
      check("wr_sel", wr_sel, m_wr_sel);
      check("wr_data", wr_data, m_wr_data);
      nb = m_busy;
      if (m_wr_en) nb[m_wr_sel] = 1'b0;
      if (rsv_valid && !m_busy[rsv_sel]) nb[rsv_sel] = 1'b1;
      m_busy = nb;
      if (g >= 0) begin
         m_wr_en   = 1'b1;
         m_wr_sel  = req_sel[4*g +: 4];
         m_wr_data = req_data[TAM*g +: TAM];
`ifndef REGWR_FIXED_PRIO_EN
         m_ptr     = (g + 1) % NREQ;
`endif
      end else begin
         m_wr_en = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   logic [NREQ-1:0] rr;
   logic            rs, ha, hb;
   logic [2:0]      fair_exp [6];
   int              fair_idx [6];
   int              rsv_list [6];
   logic [NREQ-1:0] last_acc;

   initial begin
`ifdef REGWR_FIXED_PRIO_EN
      fair_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
      fair_idx = '{0, 0, 0, 0, 0, 0};
`else
      fair_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      fair_idx = '{0, 1, 2, 0, 1, 2};
`endif
      rsv_list = '{0, 1, 2, 8, 10, 11};

      rst = 1'b1; req_valid = '1; req_sel = '0; req_data = '0;
      rsv_valid = 1'b1; rsv_sel = 4'd0; rd_sel_a = 4'd0; rd_sel_b = 4'd0;
      model_reset();
      #12;
      check("rst_req_ready", req_ready, 3'b000);
      check("rst_rsv_ready", rsv_ready, 1'b0);
      check("rst_wr_en", wr_en, 1'b0);
      check("rst_wr_sel", wr_sel, 4'd0);
      check("rst_wr_data", wr_data, 16'h0000);
      check("rst_busy", busy, 16'h0000);
      @(posedge clk); #1;
      rst = 1'b0; rsv_valid = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         req_sel[4*i +: 4]      = 4'(i + 1);
         req_data[TAM*i +: TAM] = TAM'(16'hA000 + i);
      end

      // Fairness with all requesters asserting
      for (int k = 0; k < 6; k++) begin
         cycle(rr, rs, ha, hb);
         check("fair_grant", rr, fair_exp[k]);
         check("fair_wr_sel", wr_sel, 4'(fair_idx[k] + 1));
         check("fair_wr_data", wr_data, 16'hA000 + fair_idx[k]);
      end

      // Single write
      req_valid = 3'b010; req_sel[7:4] = 4'd5; req_data[31:16] = 16'hBEEF;
      cycle(rr, rs, ha, hb);
      check("single_ready", rr, 3'b010);
      check("single_wr_en", wr_en, 1'b1);
      check("single_wr_sel", wr_sel, 4'd5);
      check("single_wr_data", wr_data, 16'hBEEF);
      req_valid = 3'b000;
      cycle(rr, rs, ha, hb);
      check("single_wr_en_low", wr_en, 1'b0);

      // Scoreboard round trip on r7
      rsv_valid = 1'b1; rsv_sel = 4'd7; rd_sel_a = 4'd7; rd_sel_b = 4'd7;
      cycle(rr, rs, ha, hb);
      rsv_valid = 1'b0;
      check("sb_busy_set", busy, 16'h0080);
      cycle(rr, rs, ha, hb);
      check("sb_hazard_a", ha, 1'b1);
      check("sb_hazard_b", hb, 1'b1);
      req_valid = 3'b100; req_sel[11:8] = 4'd7; req_data[47:32] = 16'h1234;
      cycle(rr, rs, ha, hb);
      req_valid = 3'b000;
      cycle(rr, rs, ha, hb);
      check("sb_hazard_strobe_cycle", ha, 1'b1);
      check("sb_busy_clear", busy, 16'h0000);
      cycle(rr, rs, ha, hb);
      check("sb_hazard_a_clear", ha, 1'b0);
      rd_sel_b = 4'd0;

      // WAW stall on r3
      rsv_valid = 1'b1; rsv_sel = 4'd3;
      cycle(rr, rs, ha, hb);
      cycle(rr, rs, ha, hb);
      check("waw_stall0", rs, 1'b0);
      cycle(rr, rs, ha, hb);
      check("waw_stall1", rs, 1'b0);
      req_valid = 3'b001; req_sel[3:0] = 4'd3; req_data[15:0] = 16'h3333;
      cycle(rr, rs, ha, hb);
      check("waw_stall_accept", rs, 1'b0);
      req_valid = 3'b000;
      cycle(rr, rs, ha, hb);
      check("waw_stall_strobe", rs, 1'b0);
      cycle(rr, rs, ha, hb);
      check("waw_release", rs, 1'b1);
      rsv_valid = 1'b0;

      // Collision: strobe to r9 and reservation of r9 on the same edge
      req_valid = 3'b001; req_sel[3:0] = 4'd9; req_data[15:0] = 16'h9999;
      cycle(rr, rs, ha, hb);
      req_valid = 3'b000; rsv_valid = 1'b1; rsv_sel = 4'd9;
      cycle(rr, rs, ha, hb);
      check("coll_rsv_ready", rs, 1'b1);
      rsv_valid = 1'b0;
      check("coll_busy9", busy[9], 1'b1);

      // Asynchronous reset mid-cycle with busy=0F0F and a strobe pending
      for (int k = 0; k < 6; k++) begin
         rsv_valid = 1'b1; rsv_sel = 4'(rsv_list[k]);
         cycle(rr, rs, ha, hb);
      end
      rsv_valid = 1'b0;
      req_valid = 3'b010; req_sel[7:4] = 4'd4; req_data[31:16] = 16'h4444;
      cycle(rr, rs, ha, hb);
      check("pre_rst_busy", busy, 16'h0F0F);
      check("pre_rst_wr_en", wr_en, 1'b1);
      rsv_valid = 1'b1; rsv_sel = 4'd5;
      #2 rst = 1'b1;
      #1;
      check("arst_wr_en", wr_en, 1'b0);
      check("arst_wr_sel", wr_sel, 4'd0);
      check("arst_wr_data", wr_data, 16'h0000);
      check("arst_busy", busy, 16'h0000);
      check("arst_req_ready", req_ready, 3'b000);
      check("arst_rsv_ready", rsv_ready, 1'b0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 3'b000; rsv_valid = 1'b0;
      cycle(rr, rs, ha, hb);
      check("post_rst_no_strobe", wr_en, 1'b0);

      // Randomized traffic; requesters hold sel/data until accepted
      last_acc = '1;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || last_acc[i]) begin
               req_valid[i]           = 1'($urandom_range(0, 1));
               req_sel[4*i +: 4]      = 4'($urandom_range(0, 15));
               req_data[TAM*i +: TAM] = TAM'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsv_valid = 1'($urandom_range(0, 1));
         rsv_sel   = 4'($urandom_range(0, 15));
         rd_sel_a  = 4'($urandom_range(0, 15));
         rd_sel_b  = 4'($urandom_range(0, 15));
         cycle(rr, rs, ha, hb);
         last_acc = rr & req_valid;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
